// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the streaming Sobel edge detector.
package sobel_pkg;

  localparam logic [1:0] SOBEL_L1  = 2'd0;
  localparam logic [1:0] SOBEL_GX  = 2'd1;
  localparam logic [1:0] SOBEL_GY  = 2'd2;
  localparam logic [1:0] SOBEL_THR = 2'd3;

  // Signed gradient width that holds +/-4*(2^pix_width-1) without overflow.
  function automatic int unsigned grad_width(input int unsigned pix_width);
    return pix_width + 4;
  endfunction

  // Clamp to the largest value representable in pix_width bits.
  function automatic logic [31:0] sat(input logic [31:0] x, input int unsigned pix_width);
    logic [31:0] max_val;
    max_val = (32'd1 << pix_width) - 32'd1;
    return (x > max_val) ? max_val : x;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixels: combinational read of the old word, write on the clock edge.
module sobel_line_buffer #(
  parameter int unsigned DEPTH  = 720,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  assign rd_data = r_mem[addr];

  always_ff @(posedge clock) begin
    if (en) r_mem[addr] <= wr_data;
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel operator: raster pixels in, one result per pixel out through
// a three-stage pipeline that stalls as a whole on output backpressure.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int unsigned PIX_WIDTH  = 8,
  parameter int unsigned IMG_WIDTH  = 720,
  parameter int unsigned IMG_HEIGHT = 540
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic [PIX_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PIX_WIDTH-1:0] out_data,
  input  logic [1:0]           mode,
  input  logic [PIX_WIDTH-1:0] threshold
);

  localparam int unsigned GRAD_W = grad_width(PIX_WIDTH);
  localparam int unsigned MAG_W  = GRAD_W + 1;
  localparam int unsigned COL_W  = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W  = $clog2(IMG_HEIGHT);

  logic                 w_adv, w_accept;
  logic [COL_W-1:0]     r_col, w_pos_col, w_nxt_col;
  logic [ROW_W-1:0]     r_row, w_pos_row, w_nxt_row;
  logic [PIX_WIDTH-1:0] w_lb0_rd, w_lb1_rd;
  logic [PIX_WIDTH-1:0] r_win [3][3];
  logic                 r_s1_valid, r_s1_border;
  logic                 r_s2_valid, r_s2_border;
  logic signed [GRAD_W-1:0] w_p [3][3];
  logic signed [GRAD_W-1:0] w_gx, w_gy, r_gx, r_gy;
  logic [GRAD_W-1:0]    w_abs_gx, w_abs_gy;
  logic [MAG_W-1:0]     w_mag;
  logic [PIX_WIDTH-1:0] w_s3_data;
  logic                 r_out_valid;
  logic [PIX_WIDTH-1:0] r_out_data;

  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = w_adv && !reset;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Position of the incoming pixel; start-of-frame overrides the counters.
  always_comb begin
    w_pos_col = in_sof ? '0 : r_col;
    w_pos_row = in_sof ? '0 : r_row;
    w_nxt_col = w_pos_col + COL_W'(1);
    w_nxt_row = w_pos_row;
    if (w_pos_col == COL_W'(IMG_WIDTH - 1)) begin
      w_nxt_col = '0;
      w_nxt_row = (w_pos_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : w_pos_row + ROW_W'(1);
    end
  end

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_WIDTH), .ADDR_W(COL_W)) u_lb_prev1 (
    .clock   (clock),
    .en      (w_accept),
    .addr    (w_pos_col),
    .wr_data (in_data),
    .rd_data (w_lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_WIDTH), .ADDR_W(COL_W)) u_lb_prev2 (
    .clock   (clock),
    .en      (w_accept),
    .addr    (w_pos_col),
    .wr_data (w_lb0_rd),
    .rd_data (w_lb1_rd)
  );

  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w_p[i][j] = $signed(GRAD_W'(r_win[i][j]));
    w_gx = (w_p[0][2] + (w_p[1][2] <<< 1) + w_p[2][2])
         - (w_p[0][0] + (w_p[1][0] <<< 1) + w_p[2][0]);
    w_gy = (w_p[2][0] + (w_p[2][1] <<< 1) + w_p[2][2])
         - (w_p[0][0] + (w_p[0][1] <<< 1) + w_p[0][2]);
  end

  // Stage 3 result: magnitude, mode select and border mask.
  always_comb begin
    w_abs_gx  = r_gx[GRAD_W-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
    w_abs_gy  = r_gy[GRAD_W-1] ? $unsigned(-r_gy) : $unsigned(r_gy);
    w_mag     = (MAG_W'(w_abs_gx) + MAG_W'(w_abs_gy)) >> 1;
    w_s3_data = '0;
    case (mode)
      SOBEL_L1:  w_s3_data = PIX_WIDTH'(sat(32'(w_mag), PIX_WIDTH));
      SOBEL_GX:  w_s3_data = PIX_WIDTH'(sat(32'(w_abs_gx), PIX_WIDTH));
      SOBEL_GY:  w_s3_data = PIX_WIDTH'(sat(32'(w_abs_gy), PIX_WIDTH));
      SOBEL_THR: w_s3_data = (w_mag >= MAG_W'(threshold)) ? '1 : '0;
      default:   w_s3_data = '0;
    endcase
    if (r_s2_border) w_s3_data = '0;
  end

  // Control path: counters, stage valids, border flags and the output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_border <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_border <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_adv) begin
      r_s1_valid  <= w_accept;
      r_s2_valid  <= r_s1_valid;
      r_s2_border <= r_s1_border;
      r_out_valid <= r_s2_valid;
      if (w_accept) begin
        r_col       <= w_nxt_col;
        r_row       <= w_nxt_row;
        r_s1_border <= (w_pos_row < ROW_W'(2)) || (w_pos_col < COL_W'(2));
      end
      if (r_s2_valid) r_out_data <= w_s3_data;
    end
  end

  // Datapath registers need no reset; the valids qualify them.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
      end
      r_win[0][2] <= w_lb1_rd;
      r_win[1][2] <= w_lb0_rd;
      r_win[2][2] <= in_data;
    end
    if (w_adv && r_s1_valid) begin
      r_gx <= w_gx;
      r_gy <= w_gy;
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream: pattern table, random backpressure, sof and reset cases.
module tb_sobel_stream;
  import sobel_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       drv_valid, drv_sof;
  logic [7:0] drv_data;
  logic       out_ready;
  logic [1:0] mode;
  logic [7:0] threshold;
  logic       sel;
  logic       rdy_a, rdy_b, ov_a, ov_b;
  logic [7:0] od_a, od_b;
  logic       w_in_ready, w_out_valid;
  logic [7:0] w_out_data;

  always #5 clock = ~clock;

  sobel_stream #(.PIX_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(6)) dut_a (
    .clock(clock), .reset(reset), .in_valid(drv_valid && !sel), .in_ready(rdy_a),
    .in_sof(drv_sof), .in_data(drv_data), .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .mode(mode), .threshold(threshold)
  );

  sobel_stream #(.PIX_WIDTH(8), .IMG_WIDTH(16), .IMG_HEIGHT(4)) dut_b (
    .clock(clock), .reset(reset), .in_valid(drv_valid && sel), .in_ready(rdy_b),
    .in_sof(drv_sof), .in_data(drv_data), .out_valid(ov_b), .out_ready(out_ready),
    .out_data(od_b), .mode(mode), .threshold(threshold)
  );

  assign w_in_ready  = sel ? rdy_b : rdy_a;
  assign w_out_valid = sel ? ov_b : ov_a;
  assign w_out_data  = sel ? od_b : od_a;

  typedef enum int {K_FLAT, K_VERT, K_HORZ} kind_t;
  typedef struct {
    kind_t      kind;
    int         level;
    logic [1:0] mode;
    int         thr;
    int         exp_hit;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] img[16][16];
  int         q[$];
  int         checks, passes, cyc;
  int         W, H, pos_r, pos_c, cur;
  bit         use_table, rand_ready, lat_arm;
  int         t_acc, t_val;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int pix_at(kind_t k, int lvl, int r, int c);
    case (k)
      K_VERT:  return (c >= 4) ? lvl : 0;
      K_HORZ:  return (r >= 3) ? lvl : 0;
      default: return lvl;
    endcase
  endfunction

  function automatic bit hit(kind_t k, int r, int c);
    case (k)
      K_VERT:  return (r >= 2) && (c == 4 || c == 5);
      K_HORZ:  return (c >= 2) && (r == 3 || r == 4);
      default: return (r >= 2) && (c >= 2);
    endcase
  endfunction

  // Reference Sobel straight from the stored image.
  function automatic int model(int r, int c);
    int p[3][3];
    int gx, gy, ax, ay, mag;
    if (r < 2 || c < 2) return 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = int'(img[r-2+i][c-2+j]);
    gx  = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy  = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    ax  = (gx < 0) ? -gx : gx;
    ay  = (gy < 0) ? -gy : gy;
    mag = (ax + ay) / 2;
    case (mode)
      SOBEL_L1: return (mag > 255) ? 255 : mag;
      SOBEL_GX: return (ax > 255) ? 255 : ax;
      SOBEL_GY: return (ay > 255) ? 255 : ay;
      default:  return (mag >= int'(threshold)) ? 255 : 0;
    endcase
  endfunction

  function automatic int expected(int r, int c);
    if (use_table) return hit(vecs[cur].kind, r, c) ? vecs[cur].exp_hit : 0;
    return model(r, c);
  endfunction

  task automatic step(input bit v, input bit sof, input int d, output bit acc);
    @(negedge clock);
    drv_valid = v;
    drv_sof   = sof;
    drv_data  = 8'(d);
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    check("in_ready", int'(w_in_ready), int'(!(w_out_valid && !out_ready)));
    if (w_out_valid && out_ready) begin
      if (q.size() == 0) check("extra_output", 1, 0);
      else check("out_data", int'(w_out_data), q.pop_front());
    end
    if (lat_arm && t_acc >= 0 && t_val < 0 && w_out_valid) t_val = cyc;
    acc = v && w_in_ready;
    if (acc) begin
      if (lat_arm && t_acc < 0) t_acc = cyc;
      if (sof) begin pos_r = 0; pos_c = 0; end
      img[pos_r][pos_c] = 8'(d);
      q.push_back(expected(pos_r, pos_c));
      pos_c++;
      if (pos_c == W) begin
        pos_c = 0;
        pos_r = (pos_r == H - 1) ? 0 : pos_r + 1;
      end
    end
    cyc++;
  endtask

  task automatic send(input bit sof, input int d);
    bit acc;
    int n;
    n = 0;
    do begin
      step(1'b1, sof, d, acc);
      n++;
    end while (!acc && n < 100);
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (q.size() > 0 && n < 500) begin
      step(1'b0, 1'b0, 0, acc);
      n++;
    end
    check("drain_empty", q.size(), 0);
    q.delete();
    repeat (4) step(1'b0, 1'b0, 0, acc);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; drv_valid = 1'b0; drv_sof = 1'b0; drv_data = '0;
    out_ready = 1'b1; mode = SOBEL_L1; threshold = '0; sel = 1'b0;
    checks = 0; passes = 0; cyc = 0; cur = 0;
    use_table = 1'b0; rand_ready = 1'b0; lat_arm = 1'b0;
    W = 8; H = 6; pos_r = 0; pos_c = 0; t_acc = -1; t_val = -1;

    vecs[0] = '{K_FLAT, 100, SOBEL_L1,  0,  0};
    vecs[1] = '{K_VERT, 40,  SOBEL_L1,  0,  80};
    vecs[2] = '{K_VERT, 255, SOBEL_GX,  0,  255};
    vecs[3] = '{K_VERT, 40,  SOBEL_THR, 50, 255};
    vecs[4] = '{K_VERT, 40,  SOBEL_THR, 90, 0};
    vecs[5] = '{K_FLAT, 100, SOBEL_THR, 0,  255};
    vecs[6] = '{K_HORZ, 40,  SOBEL_GY,  0,  160};
    vecs[7] = '{K_VERT, 255, SOBEL_L1,  0,  255};

    repeat (2) @(negedge clock);
    #1;
    check("reset_out_valid", int'(ov_a), 0);
    check("reset_in_ready_a", int'(rdy_a), 0);
    check("reset_in_ready_b", int'(rdy_b), 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_reset_out_valid", int'(ov_a), 0);
    check("post_reset_out_data", int'(od_a), 0);
    check("post_reset_in_ready", int'(rdy_a), 1);

    // Pattern frames with hand-derived expectations.
    use_table = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cur = i;
      mode = vecs[i].mode;
      threshold = 8'(vecs[i].thr);
      for (int idx = 0; idx < 48; idx++)
        send(idx == 0, pix_at(vecs[i].kind, vecs[i].level, idx / 8, idx % 8));
      drain();
    end
    use_table = 1'b0;

    // Random 16x4 frame with random sink backpressure.
    sel = 1'b1; W = 16; H = 4; mode = SOBEL_L1; rand_ready = 1'b1;
    for (int idx = 0; idx < 64; idx++) send(idx == 0, int'($urandom_range(0, 255)));
    drain();
    rand_ready = 1'b0;

    // Start-of-frame arriving mid-frame at pixel 20.
    sel = 1'b0; W = 8; H = 6;
    for (int idx = 0; idx < 20; idx++) send(idx == 0, int'($urandom_range(0, 255)));
    send(1'b1, int'($urandom_range(0, 255)));
    for (int idx = 1; idx < 48; idx++) send(1'b0, int'($urandom_range(0, 255)));
    drain();

    // One-cycle reset at pixel 30, then a frame without sof.
    for (int idx = 0; idx < 30; idx++) send(idx == 0, int'($urandom_range(0, 255)));
    @(negedge clock);
    reset = 1'b1; drv_valid = 1'b1; drv_sof = 1'b0; out_ready = 1'b1;
    #1;
    check("in_ready_during_reset", int'(w_in_ready), 0);
    @(negedge clock);
    reset = 1'b0; drv_valid = 1'b0;
    #1;
    check("out_valid_after_reset", int'(w_out_valid), 0);
    q.delete();
    pos_r = 0; pos_c = 0;
    lat_arm = 1'b1; t_acc = -1; t_val = -1;
    for (int idx = 0; idx < 48; idx++) send(1'b0, int'($urandom_range(0, 255)));
    drain();
    check("latency", t_val - t_acc, 3);
    lat_arm = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
# sobel_stream

Streaming, parametrised Sobel edge detector: it accepts one raster-order pixel per handshake, keeps the 3x3 neighbourhood in two internal line buffers, and emits exactly one result pixel per input pixel through a 3-stage valid/ready pipeline. Pixel width, image size and output mode are configurable. It sits between the pixel source (camera/DMA reader) and the output sink, replacing window-fed Sobel operators that need an external 3x3 window builder.

## Interface
- PIX_WIDTH, 8, bits per unsigned greyscale pixel (in and out)
- IMG_WIDTH, 720, pixels per line; line-buffer depth
- IMG_HEIGHT, 540, lines per frame
- clock  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts pixel this cycle
- in_sof  in  1  start-of-frame; qualifies in_data as pixel (0,0)
- in_data  in  PIX_WIDTH  input pixel
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- out_data  out  PIX_WIDTH  result pixel
- mode  in  2  0 L1 magnitude, 1 |gx|, 2 |gy|, 3 binary threshold
- threshold  in  PIX_WIDTH  compare level for mode 3

## Operation
- Accept when in_valid && in_ready. Each accepted pixel advances col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1).
- Counter wrap: col wraps to 0 and row increments; after (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0.
- in_sof on an accepted pixel forces that pixel to (0,0) regardless of counters; counters continue from (0,1).
- Line buffers: two RAMs indexed by col. Each accept reads the two older lines' pixels at col, then writes the shift-down. Line buffers are not cleared at a frame start; the border rule masks stale data.
- Window: the result for accepted pixel (r,c) uses rows r-2..r and cols c-2..c. Let P[i][j] be the pixel at window row i, column j (0 = top/left, all unsigned).
- gx = (P0[2] + 2·P1[2] + P2[2]) − (P0[0] + 2·P1[0] + P2[0]).
- gy = (P2[0] + 2·P2[1] + P2[2]) − (P0[0] + 2·P0[1] + P0[2]).
- Widths: pixels are zero-extended. gx and gy are signed with GRAD_W = PIX_WIDTH+4 bits, which cannot overflow.
- mag = (|gx| + |gy|) >> 1, computed in GRAD_W+1 bits.
- Saturation: sat(x) = min(x, 2^PIX_WIDTH − 1).
- Output per mode: mode 0 outputs sat(mag). Mode 1 outputs sat(|gx|). Mode 2 outputs sat(|gy|). Mode 3 outputs all-ones if mag ≥ threshold, else 0.
- Border: if r<2 or c<2, out_data = 0 in every mode, including mode 3 with threshold 0.
- mode/threshold are quasi-static and applied at stage 3. A change takes effect on the next result computed in stage 3.
- Reset values: out_valid=0, out_data=0, row=col=0, all stage valids 0. in_ready=0 while reset is high.

## Timing
- Pipeline stages:
  - S1: accept, counter update, line-buffer read/write, window shift.
  - S2: gx/gy.
  - S3: magnitude, mode select, border mask; registered out_data/out_valid.
- Latency: with out_ready=1 throughout, out_valid rises 3 cycles after the accepting edge.
- Throughput: 1 pixel/cycle.
- Global stall: adv = !s3_valid || out_ready. in_ready = adv && !reset. All stages hold when adv=0.
- out_data is stable while out_valid && !out_ready.
- Accept and emit in the same cycle are allowed.
- Reset mid-frame: all pipeline contents are discarded and out_valid=0 on the cycle after reset is sampled. The next accepted pixel is (0,0).
- No result is lost or duplicated under any out_ready pattern.

## Structure
- Package sobel_pkg:
  - mode constants SOBEL_L1, SOBEL_GX, SOBEL_GY, SOBEL_THR.
  - function grad_width(pix_width) returning pix_width+4.
  - saturation function.
- Sub-module sobel_line_buffer: a single-port, read-before-write, IMG_WIDTH x PIX_WIDTH RAM with enable. Instantiated twice.
- The top level holds the counters, window registers, arithmetic pipeline and handshake.

## Test plan
- Flat frame: 8x6 frame, all pixels 100, mode 0 → 48 outputs, all 0.
- Vertical edge: 8x6 frame with cols 0–3 = 0 and cols 4–7 = 40, mode 0.
  - Rows ≥2: cols 4 and 5 = 80 (gx=160); every other col = 0.
  - Rows 0–1: all 0.
- Saturation and threshold:
  - Same edge at 255, mode 1 → 255 at cols 4 and 5.
  - Edge at 40, mode 3, threshold 50 → 255 at cols 4 and 5, else 0.
  - Edge at 40, mode 3, threshold 90 → all 0.
- Backpressure: 16x4 random frame, pseudo-random out_ready (50%).
  - Output sequence equals the reference model.
  - in_ready is low exactly when out_valid && !out_ready.
- Mid-frame in_sof: assert in_sof at pixel index 20 of an 8x6 frame → the next 16 outputs are 0 (border rows), then correct gradients resume.
- Reset mid-frame: reset for 1 cycle at pixel 30 → out_valid=0 the next cycle; a following clean frame matches the model with latency 3.
